// File: rtl/matrix_loader.sv
// matrix_loader: packs a stream of int8 elements into one
// 256-bit word and writes it to the shared operand RAM.
module matrix_loader #(
  parameter int N_ELEM = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [7:0]   dest_addr,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [7:0]   mem_address,
  output logic [255:0] mem_data,
  output logic         mem_wren,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t       r_state;
  logic [5:0]   r_cnt;
  logic [255:0] r_buf;
  logic [7:0]   r_addr;
  logic         r_in_ready;
  logic [7:0]   r_mem_addr;
  logic [255:0] r_mem_data;
  logic         r_mem_wren;
  logic         r_busy;
  logic         r_done;

  logic [255:0] w_buf_nx;
  logic         w_last;

  assign w_last = (r_cnt == 6'(N_ELEM - 1));

  // Buffer with the current element dropped into slot r_cnt
  always_comb begin
    w_buf_nx = r_buf;
    w_buf_nx[{r_cnt[4:0], 3'b000} +: 8] = in_data;
  end

  // Load FSM; every output is a register updated on transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_addr     <= '0;
      r_in_ready <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wren <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_mem_wren <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= dest_addr;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (abort) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (in_valid) begin
            r_buf <= w_buf_nx;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_mem_wren <= 1'b1;
              r_mem_addr <= r_addr;
              r_mem_data <= w_buf_nx;
              r_state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign mem_address = r_mem_addr;
  assign mem_data    = r_mem_data;
  assign mem_wren    = r_mem_wren;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
